// File: rtl/sr_cmd_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : sr_cmd_driver_if
//  Description : Bundle of the command stream (valid/ready/data) and the
//                excitation/feedback wires of the external SR latch.
//                The slave modport is the driver; the master modport is the
//                environment (command source plus the latch itself).
//  Revision    : 1.0 - initial release
// ============================================================================
interface sr_cmd_driver_if;
  logic tgt_valid;   // desired latch value presented
  logic tgt_data;    // desired Q value
  logic tgt_ready;   // driver FIFO can take an entry
  logic s_out;       // set excitation to latch S
  logic r_out;       // reset excitation to latch R
  logic en_out;      // gate pulse to latch enable
  logic q_fb;        // latch Q, asynchronous to clk

  modport slave (
    input  tgt_valid,
    input  tgt_data,
    input  q_fb,
    output tgt_ready,
    output s_out,
    output r_out,
    output en_out
  );

  modport master (
    output tgt_valid,
    output tgt_data,
    output q_fb,
    input  tgt_ready,
    input  s_out,
    input  r_out,
    input  en_out
  );
endinterface
`default_nettype wire

// File: rtl/sr_cmd_driver.sv
`default_nettype none
// ============================================================================
//  Module      : sr_cmd_driver
//  Description : Command-side driver for an external gated SR latch. Desired
//                Q values are queued in a small FIFO; each one is applied as
//                an S or R excitation with a gate pulse (or skipped when the
//                latch already holds that value), then Q is read back through
//                a 2-flop synchronizer and any disagreement is counted.
//  Revision    : 1.0 - initial release
// ============================================================================
module sr_cmd_driver #(
  parameter int FIFO_DEPTH    = 4,  // power of two, >= 2
  parameter int PULSE_CYCLES  = 2,  // >= 1
  parameter int SETTLE_CYCLES = 3,  // >= 1
  parameter int ERR_W         = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  sr_cmd_driver_if.slave        bus,
  output logic                  busy,
  output logic                  mismatch,
  output logic [ERR_W-1:0]      err_count,
  output logic                  cur_q
);

  // --------------------------------------------------------------------------
  // Derived sizes
  // --------------------------------------------------------------------------
  localparam int c_AW      = $clog2(FIFO_DEPTH);
  localparam int c_CNT_MAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  // The phase counter only ever holds (cycles - 1), so clog2(max) bits suffice.
  localparam int c_CW      = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

  localparam logic [c_AW:0]   c_FULL        = (c_AW+1)'(FIFO_DEPTH);
  localparam logic [c_CW-1:0] c_PULSE_LAST  = c_CW'(PULSE_CYCLES - 1);
  localparam logic [c_CW-1:0] c_SETTLE_LAST = c_CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SETTLE = 2'd2,
    S_CHECK  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic                  r_q_meta;
  logic                  r_q_sync;

  logic [FIFO_DEPTH-1:0] r_mem;
  logic [c_AW-1:0]       r_wr_ptr;
  logic [c_AW-1:0]       r_rd_ptr;
  logic [c_AW:0]         r_count;
  logic                  r_ready;

  state_t                r_state;
  logic                  r_tgt;
  logic [c_CW-1:0]       r_cnt;
  logic                  r_en;
  logic                  r_s;
  logic                  r_r;
  logic                  r_mismatch;
  logic [ERR_W-1:0]      r_err;
  logic                  r_cur_q;
  logic                  r_known;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic                  w_push;
  logic                  w_pop;
  logic                  w_empty;
  logic                  w_head;
  logic [c_AW:0]         w_count_nxt;
  logic [ERR_W-1:0]      w_err_next;

  // Ready is registered, so it reads "not full" as of the last edge and is 0
  // while in reset; a push can therefore never land on a full FIFO.
  assign w_push  = bus.tgt_valid & r_ready;
  assign w_empty = (r_count == '0);
  assign w_pop   = (r_state == S_IDLE) & ~w_empty;
  assign w_head  = r_mem[r_rd_ptr];

  // Saturating increment: the counter sticks at all-ones.
  assign w_err_next = (&r_err) ? r_err : (r_err + 1'b1);

  // Occupancy after this edge, used both for the count and for next ready.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Two-flop synchronizer for the asynchronous latch feedback
  // --------------------------------------------------------------------------
  // Bring q_fb into the clk domain before any decision uses it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_meta <= 1'b0;
      r_q_sync <= 1'b0;
    end else begin
      r_q_meta <= bus.q_fb;
      r_q_sync <= r_q_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Command FIFO
  // --------------------------------------------------------------------------
  // Storage, pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= bus.tgt_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != c_FULL);
    end
  end

  // --------------------------------------------------------------------------
  // Excitation / verification sequencer
  // --------------------------------------------------------------------------
  // IDLE pops a command and either pulses the latch or goes straight to a
  // hold check. The read-back comparison is registered on the edge that
  // enters CHECK, so mismatch and the counter step both show in CHECK itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_tgt      <= 1'b0;
      r_cnt      <= '0;
      r_en       <= 1'b0;
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_mismatch <= 1'b0;
      r_err      <= '0;
      r_cur_q    <= 1'b0;
      r_known    <= 1'b0;
    end else begin
      r_mismatch <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_tgt <= w_head;
            if (!r_known || (w_head != r_cur_q)) begin
              // Latch must change (or its state is unknown): drive it.
              r_state <= S_DRIVE;
              r_en    <= 1'b1;
              r_s     <= w_head;
              r_r     <= ~w_head;
              r_cnt   <= c_PULSE_LAST;
            end else begin
              // Latch already holds the value: only verify it.
              r_state <= S_CHECK;
              if (r_q_sync != w_head) begin
                r_mismatch <= 1'b1;
                r_err      <= w_err_next;
              end
            end
          end
        end

        S_DRIVE: begin
          if (r_cnt == '0) begin
            r_state <= S_SETTLE;
            r_en    <= 1'b0;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            r_cnt   <= c_SETTLE_LAST;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        S_SETTLE: begin
          if (r_cnt == '0) begin
            r_state <= S_CHECK;
            if (r_q_sync != r_tgt) begin
              r_mismatch <= 1'b1;
              r_err      <= w_err_next;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        S_CHECK: begin
          r_cur_q <= r_tgt;
          r_known <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.tgt_ready = r_ready;
  assign bus.en_out    = r_en;
  assign bus.s_out     = r_s;
  assign bus.r_out     = r_r;
  assign busy          = (r_state != S_IDLE) | ~w_empty;
  assign mismatch      = r_mismatch;
  assign err_count     = r_err;
  assign cur_q         = r_cur_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_cmd_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sr_cmd_driver
//  Description : Self-checking bench for sr_cmd_driver. A second instance with
//                a 2-bit error counter shares the same stimulus to observe
//                saturation. Expected per-cycle outputs come from a schedule
//                computed from the command timing rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_cmd_driver;

  localparam int c_DEPTH  = 4;
  localparam int c_PULSE  = 2;
  localparam int c_SETTLE = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  bit   chk_en = 1'b0;
  bit   tie0   = 1'b0;
  logic q_lat  = 1'b0;
  int   mm_seen = 0;

  sr_cmd_driver_if ifc ();
  sr_cmd_driver_if ifc2 ();

  logic       busy, mm, cq;
  logic [7:0] err;
  logic       busy2, mm2, cq2;
  logic [1:0] err2;

  sr_cmd_driver #(.FIFO_DEPTH(c_DEPTH), .PULSE_CYCLES(c_PULSE),
                  .SETTLE_CYCLES(c_SETTLE), .ERR_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc.slave),
    .busy(busy), .mismatch(mm), .err_count(err), .cur_q(cq));

  sr_cmd_driver #(.FIFO_DEPTH(c_DEPTH), .PULSE_CYCLES(c_PULSE),
                  .SETTLE_CYCLES(c_SETTLE), .ERR_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(ifc2.slave),
    .busy(busy2), .mismatch(mm2), .err_count(err2), .cur_q(cq2));

  assign ifc.q_fb        = tie0 ? 1'b0 : q_lat;
  assign ifc2.q_fb       = ifc.q_fb;
  assign ifc2.tgt_valid  = ifc.tgt_valid;
  assign ifc2.tgt_data   = ifc.tgt_data;

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural SR latch: S sets, R resets while the gate is high.
  initial forever begin
    @(negedge clk);
    if (ifc.en_out && ifc.s_out)      q_lat = 1'b1;
    else if (ifc.en_out && ifc.r_out) q_lat = 1'b0;
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // ---------------- reference model ----------------
  // Cycle index k = value of cyc seen at the negedge after the k-th posedge.
  bit       exp_pop[int];
  bit [1:0] exp_sr[int];       // {S,R} expected while the gate is high
  bit       exp_mm[int];
  bit       exp_cq_upd[int];
  int       exp_err_upd[int];
  int       m_occ, m_free, m_err_sched, m_err_vis;
  bit       m_known, m_cur_sched, m_cq_vis, acc_pend;

  task automatic model_clear();
    exp_pop.delete(); exp_sr.delete(); exp_mm.delete();
    exp_cq_upd.delete(); exp_err_upd.delete();
    m_occ = 0; m_free = 0; m_err_sched = 0; m_err_vis = 0;
    m_known = 0; m_cur_sched = 0; m_cq_vis = 0; acc_pend = 0;
  endtask

  // Command accepted at edge a: FSM is free to pop at max(a+1, m_free).
  // A pulse occupies 1 idle + PULSE + SETTLE + 1 check cycles, a hold 2.
  task automatic schedule(input int a, input bit d);
    int p, c;
    bit q_seen;
    p = (a + 1 > m_free) ? a + 1 : m_free;
    exp_pop[p] = 1'b1;
    if (!m_known || d != m_cur_sched) begin
      for (int i = 0; i < c_PULSE; i++) exp_sr[p+i] = {d, ~d};
      c = p + c_PULSE + c_SETTLE;
    end else begin
      c = p;
    end
    q_seen = tie0 ? 1'b0 : d;
    if (q_seen != d) begin
      m_err_sched++;
      exp_mm[c] = 1'b1;
      exp_err_upd[c] = m_err_sched;
    end
    exp_cq_upd[c+1] = d;
    m_known = 1'b1;
    m_cur_sched = d;
    m_free = c + 2;
  endtask

  // Per-cycle monitor
  initial forever begin
    bit [1:0] sr_e;
    @(negedge clk);
    if (ifc.s_out && ifc.r_out) chk("s_and_r_both", 1, 0);
    if (mm) mm_seen++;
    if (chk_en) begin
      if (acc_pend) m_occ++;
      if (exp_pop.exists(cyc)) m_occ--;
      acc_pend = 1'b0;
      if (exp_cq_upd.exists(cyc))  m_cq_vis  = exp_cq_upd[cyc];
      if (exp_err_upd.exists(cyc)) m_err_vis = exp_err_upd[cyc];
      sr_e = exp_sr.exists(cyc) ? exp_sr[cyc] : 2'b00;
      chk("ready",    ifc.tgt_ready, (m_occ < c_DEPTH));
      chk("en_s_r",   {ifc.en_out, ifc.s_out, ifc.r_out}, {|sr_e, sr_e});
      chk("mismatch", mm, exp_mm.exists(cyc));
      chk("cur_q",    cq, m_cq_vis);
      chk("err",      err, sat(m_err_vis, 8));
      chk("err2",     err2, sat(m_err_vis, 2));
      if (ifc.tgt_valid && (m_occ < c_DEPTH)) begin
        schedule(cyc + 1, ifc.tgt_data);
        acc_pend = 1'b1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input bit d, output int acc);
    ifc.tgt_data  = d;
    ifc.tgt_valid = 1'b1;
    acc = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (ifc.tgt_ready) begin
        acc = cyc + 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    ifc.tgt_valid = 1'b0;
    if (acc < 0) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!busy && !ifc.tgt_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("rst_ready",  ifc.tgt_ready, 0);
    chk("rst_en_s_r", {ifc.en_out, ifc.s_out, ifc.r_out}, 0);
    chk("rst_mm",     mm, 0);
    chk("rst_err",    err, 0);
    chk("rst_cur_q",  cq, 0);
    chk("rst_busy",   busy, 0);
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", ifc.tgt_ready, 0);
    @(posedge clk);
    #1;
    chk("ready_after_edge", ifc.tgt_ready, 1);
    chk_en = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int acc;
    int accs[5];
    int base;
    int rises;
    bit prev_en, saw;
    bit last;

    ifc.tgt_valid = 1'b0;
    ifc.tgt_data  = 1'b0;
    model_clear();
    do_reset();

    // Single set command against a real latch
    push(1'b1, acc);
    wait_idle();
    chk("t1_cur_q", cq, 1);
    chk("t1_err", err, 0);

    // 1,1,0: hold then reset pulse
    push(1'b1, acc);
    push(1'b1, acc);
    push(1'b0, acc);
    wait_idle();
    chk("t2_cur_q", cq, 0);

    // FIFO fill while the sequencer is busy with a pulse
    push(1'b1, acc);
    saw = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (ifc.en_out) begin saw = 1'b1; break; end
    end
    chk("t3_en_seen", saw, 1);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      push(i[0] ? 1'b1 : 1'b0, accs[i]);
      if (i == 3) chk("t3_ready_full", ifc.tgt_ready, 0);
    end
    chk("t3_four_consec", accs[3] - accs[0], 3);
    chk("t3_fifth_waited", (accs[4] - accs[3]) > 1, 1);
    wait_idle();
    chk("t3_cur_q", cq, 0);

    // Feedback stuck at 0: every check mismatches, 2-bit counter saturates
    tie0 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    base = mm_seen;
    for (int i = 0; i < 3; i++) push(1'b1, acc);
    wait_idle();
    chk("t4_mm_pulses", mm_seen - base, 3);
    chk("t4_err3", err, 3);
    for (int i = 0; i < 2; i++) push(1'b1, acc);
    wait_idle();
    chk("t4_err5", err, 5);
    chk("t4_err2_sat", err2, 3);
    tie0 = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Reset while the second of three queued commands is driving
    push(1'b0, acc);
    push(1'b1, acc);
    push(1'b0, acc);
    rises = 0;
    prev_en = ifc.en_out;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ifc.en_out && !prev_en) rises++;
      prev_en = ifc.en_out;
      if (rises == 2) break;
    end
    chk("t5_second_drive", rises, 2);
    #2;
    do_reset();
    chk("t5_busy_after", busy, 0);
    // Old cur_q was 0 (first command); state is unknown now, so 0 still pulses
    push(1'b0, acc);
    saw = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ifc.en_out && ifc.r_out) begin saw = 1'b1; break; end
    end
    chk("t5_pulse_after_rst", saw, 1);
    wait_idle();

    // Random stream against the latch model
    last = 1'b0;
    for (int i = 0; i < 200; i++) begin
      last = ($urandom_range(0, 1) == 1);
      push(last, acc);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1;
      end
    end
    wait_idle();
    chk("t6_err_zero", err, 0);
    chk("t6_cur_q", cq, last);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
